// File: rtl/sub_div_ctrl_pkg.sv
// Shared definitions for the repeated-subtraction divider controller.
// Holds the FSM state encoding and the default operand width.
package sub_div_ctrl_pkg;

    localparam int unsigned DEFAULT_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/sub_div_ctrl_quot_counter.sv
// Quotient counter: SIZE-bit up-counter with synchronous clear and
// increment enable. Clear wins over increment.
module sub_div_ctrl_quot_counter
    import sub_div_ctrl_pkg::*;
#(
    parameter int unsigned SIZE = DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [SIZE-1:0] count_o
);

    logic [SIZE-1:0] count_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + SIZE'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sub_div_ctrl.sv
// Divider controller driving an external subtractor register (SFR): loads the
// dividend, then subtracts the divisor while the fed-back value is >= divisor.
module sub_div_ctrl
    import sub_div_ctrl_pkg::*;
#(
    parameter int unsigned SIZE = DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    input  logic [SIZE-1:0] rem_q,
    output logic            ld,
    output logic            sub,
    output logic [SIZE-1:0] D,
    output logic [SIZE-1:0] S,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            busy,
    output logic            done,
    output logic            div_zero
);

    state_e          state_q;
    logic [SIZE-1:0] dividend_q;
    logic [SIZE-1:0] divisor_q;
    logic [SIZE-1:0] remainder_q;
    logic            div_zero_q;
    logic [SIZE-1:0] count;
    logic            accept;
    logic            rem_ge;

    assign accept = (state_q == IDLE) && start;
    assign rem_ge = (rem_q >= divisor_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dividend_q  <= '0;
            divisor_q   <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dividend_q <= dividend;
                        divisor_q  <= divisor;
                        div_zero_q <= (divisor == '0);
                        // A zero divisor skips the SFR entirely.
                        if (divisor == '0) begin
                            remainder_q <= dividend;
                            state_q     <= DONE;
                        end else begin
                            state_q     <= LOAD;
                        end
                    end
                end
                LOAD: state_q <= CMP;
                CMP: begin
                    if (!rem_ge) begin
                        remainder_q <= rem_q;
                        state_q     <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    sub_div_ctrl_quot_counter #(
        .SIZE (SIZE)
    ) u_quot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (accept),
        .inc_i   (sub),
        .count_o (count)
    );

    assign ld        = (state_q == LOAD);
    assign sub       = (state_q == CMP) && rem_ge;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign D         = dividend_q;
    assign S         = divisor_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    // Divide-by-zero reports an all-ones quotient; the counter itself stays cleared.
    assign quotient  = div_zero_q ? '1 : count;

endmodule

// File: doc/sub_div_ctrl.md
SUB_DIV_CTRL -- requirements
Module: sub_div_ctrl

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, giving the operand, quotient and remainder width.
REQ-002 clk  input  1  the single clock; all state updates SHALL occur on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  division request, sampled only in IDLE.
REQ-005 dividend  input  SIZE  numerator, sampled with start.
REQ-006 divisor  input  SIZE  denominator, sampled with start.
REQ-007 rem_q  input  SIZE  current subtractee Q fed back from the downstream subtractor SFR.
REQ-008 ld  output  1  load strobe to the SFR.
REQ-009 sub  output  1  subtract-enable to the SFR.
REQ-010 D  output  SIZE  base subtractee to the SFR, equal to the latched dividend.
REQ-011 S  output  SIZE  subtractor to the SFR, equal to the latched divisor.
REQ-012 quotient  output  SIZE  result quotient, held until the next accepted start.
REQ-013 remainder  output  SIZE  result remainder, held until the next accepted start.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 div_zero  output  1  high with done when divisor==0, and held until the next accepted start.

Function
REQ-017 The FSM SHALL have four states, IDLE, LOAD, CMP and DONE, with ld, sub, busy and done decoded from the state.
REQ-018 IDLE with start=1: dividend and divisor SHALL be latched, quotient cleared, div_zero cleared; next state LOAD if divisor!=0, else DONE.
REQ-019 Divisor==0: the block SHALL set div_zero=1, quotient=all ones and remainder=dividend, and SHALL never assert ld or sub.
REQ-020 LOAD: ld=1 and sub=0 for exactly one cycle; next state CMP.
REQ-021 CMP with rem_q>=S (unsigned): sub=1, quotient increments by 1 at the edge, and the state stays CMP.
REQ-022 CMP with rem_q<S: sub=0, remainder<=rem_q; next state DONE.
REQ-023 DONE: done=1 for one cycle; next state IDLE.
REQ-024 Latency: with the start cycle numbered 0, done SHALL be high in cycle N+3 for a nonzero divisor, where N is the final quotient, and in cycle 1 for a zero divisor.
REQ-025 start while busy SHALL be ignored, with no effect on the latched operands or the results.
REQ-026 ld and sub SHALL never be high in the same cycle.
REQ-027 Quotient cannot overflow since divisor>=1; no saturation logic is required.
REQ-028 The rem_q>=S compare SHALL be unsigned, full SIZE width.

Reset
REQ-029 With rst_n=0 at an edge, the block SHALL enter IDLE and clear quotient, remainder, the latched operands and div_zero; ld, sub, busy and done SHALL be 0.
REQ-030 Reset mid-operation SHALL abort the division; the next start after reset SHALL run a full division normally.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE/LOAD/CMP/DONE) and the default SIZE constant.
REQ-032 One sub-module is natural: quot_counter, a SIZE-bit counter with synchronous clear and increment enable; all other logic stays inline.
REQ-033 The bench SHALL close the loop by connecting ld/sub/D/S to a behavioural subtractor SFR model that drives rem_q.

Verification
REQ-034 100/7 -> quotient=14, remainder=2, done in cycle 17, sub high for exactly 14 cycles.
REQ-035 5/9 -> quotient=0, remainder=5, done in cycle 3, sub never high.
REQ-036 9/9 -> quotient=1, remainder=0, done in cycle 4.
REQ-037 42/0 -> done in cycle 1, div_zero=1, quotient=32'hFFFFFFFF, remainder=42, ld and sub never high.
REQ-038 Start 100/7, pulse start with 50/5 at cycle 5, then assert rst_n=0 at cycle 8 on a rerun -> the second start is ignored and results match REQ-034; after the reset, outputs are 0, the state is IDLE, and a new 20/3 run gives quotient=6, remainder=2.
